div_sched: RTL and testbench
============================

DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter CORE_LAT, default 2, divider core latency in cycles (1..15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_dividend  input  8  requester 0 dividend, unsigned.
REQ-007 req0_divisor  input  4  requester 0 divisor, unsigned.
REQ-008 req1_valid, req1_ready, req1_dividend, req1_divisor: same as REQ-004..007 for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes result.
REQ-011 rsp_id  output  1  requester that owns the result.
REQ-012 rsp_quotient  output  8  unsigned quotient.
REQ-013 rsp_remainder  output  4  unsigned remainder.
REQ-014 rsp_dbz  output  1  divisor was zero.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done_count  output  16  completed responses, wraps at 65535->0.

Function
REQ-017 FSM states IDLE, COMPUTE, RESP; one operation in flight at a time.
REQ-018 In IDLE, reqN_ready SHALL be high only for the granted requester, combinationally from valids and rr pointer; never both high.
REQ-019 Arbitration SHALL be round-robin: one valid wins; both valid -> requester other than last granted wins.
REQ-020 Handshake SHALL complete when reqN_valid and reqN_ready are both high; operands and id SHALL be registered on that edge.
REQ-021 Accept with divisor != 0: IDLE->COMPUTE, cycle counter loaded CORE_LAT-1, decremented each cycle; at 0 capture core outputs, ->RESP.
REQ-022 rsp_valid SHALL first be high CORE_LAT+1 cycles after the accepting edge (3 cycles at default).
REQ-023 Accept with divisor == 0: IDLE->RESP next cycle, core bypassed; rsp_quotient=8'hFF, rsp_remainder=dividend[3:0], rsp_dbz=1.
REQ-024 In RESP, rsp_valid high and all rsp_* outputs SHALL hold stable until rsp_ready; rsp_valid&rsp_ready -> IDLE, done_count+1.
REQ-025 No request SHALL be accepted in COMPUTE or RESP (both reqN_ready low); a new accept is earliest the cycle after the RESP handshake.
REQ-026 Quotient and remainder SHALL satisfy dividend = quotient*divisor + remainder, remainder < divisor, for all nonzero divisors.
REQ-027 rsp_dbz SHALL be 0 for every nonzero divisor.
REQ-028 Requester inputs changing while not ready SHALL have no effect.

Reset
REQ-029 rst_n low at any edge, including mid-COMPUTE or RESP, SHALL force IDLE and abandon the operation without a response.
REQ-030 Reset values: rsp_valid=0, rsp_id=0, rsp_quotient=0, rsp_remainder=0, rsp_dbz=0, busy=0, done_count=0, counter=0, rr pointer = requester 0 wins first tie.
REQ-031 reqN_ready SHALL be low while rst_n is low.

Structure
REQ-032 Package div_sched_pkg SHALL hold the state enum, operand/result width constants and the DBZ quotient constant 8'hFF.
REQ-033 One sub-module, div_core: combinational unsigned 8/4 divider; div_sched adds the CORE_LAT timing and captures outputs at counter 0.
REQ-034 No other sub-modules; arbiter, FSM, counters inline.

Verification
REQ-035 req0 200/7, rsp_ready=1 -> rsp_valid at accept+3, q=28, r=4, id=0, dbz=0, done_count=1.
REQ-036 req1 255/15 then req1 9/10 -> q=17 r=0; then q=0 r=9.
REQ-037 req0 100/0 -> rsp_valid at accept+1, q=8'hFF, r=4, dbz=1.
REQ-038 Both requesters held valid for 4 ops, rsp_ready=1 -> ids 0,1,0,1; no cycle with both ready high.
REQ-039 rsp_ready low 5 cycles in RESP -> rsp_* stable, both reqN_ready low, done_count unchanged until handshake.
REQ-040 rst_n low one cycle mid-COMPUTE -> next cycle IDLE, busy=0, rsp_valid=0, done_count=0; following req0 64/8 -> q=8 r=0.

Source files
------------

// File: rtl/div_sched_pkg.sv
// rtl/div_sched_pkg.sv - shared types and constants for the divide scheduler
package div_sched_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int QUOT_W     = 8;
  localparam int REM_W      = 4;
  localparam int CNT_W      = 4;
  localparam int DONE_W     = 16;

  // Quotient reported when the divisor is zero
  localparam logic [QUOT_W-1:0] DBZ_QUOTIENT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_RESP    = 2'd2
  } state_e;

endpackage

// File: rtl/div_core.sv
// rtl/div_core.sv - combinational unsigned 8/4 restoring divider
module div_core
  import div_sched_pkg::*;
(
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic [QUOT_W-1:0]     quotient_o,
  output logic [REM_W-1:0]      remainder_o
);

  // Partial remainder needs one bit more than the divisor before each subtract
  logic [DIVISOR_W:0] part;

  // Long division, one quotient bit per dividend bit, MSB first
  always_comb begin
    part       = '0;
    quotient_o = '0;
    for (int i = DIVIDEND_W - 1; i >= 0; i--) begin
      part = {part[DIVISOR_W-1:0], dividend_i[i]};
      if (part >= {1'b0, divisor_i}) begin
        part          = part - {1'b0, divisor_i};
        quotient_o[i] = 1'b1;
      end
    end
    remainder_o = part[REM_W-1:0];
  end

endmodule

// File: rtl/div_sched.sv
// rtl/div_sched.sv - two-requester round-robin scheduler around a timed divider
module div_sched
  import div_sched_pkg::*;
#(
  parameter int CORE_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DIVIDEND_W-1:0] req0_dividend,
  input  logic [DIVISOR_W-1:0]  req0_divisor,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DIVIDEND_W-1:0] req1_dividend,
  input  logic [DIVISOR_W-1:0]  req1_divisor,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [QUOT_W-1:0]     rsp_quotient,
  output logic [REM_W-1:0]      rsp_remainder,
  output logic                  rsp_dbz,
  output logic                  busy,
  output logic [DONE_W-1:0]     done_count
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CORE_LAT - 1);

  state_e                 state_q;
  logic                   last_id_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DIVIDEND_W-1:0]  dividend_q;
  logic [DIVISOR_W-1:0]   divisor_q;
  logic                   id_q;
  logic                   rsp_valid_q;
  logic                   rsp_id_q;
  logic [QUOT_W-1:0]      rsp_quot_q;
  logic [REM_W-1:0]       rsp_rem_q;
  logic                   rsp_dbz_q;
  logic                   busy_q;
  logic [DONE_W-1:0]      done_q;

  logic                   grant0;
  logic                   grant1;
  logic                   accept;
  logic                   accept_id;
  logic [DIVIDEND_W-1:0]  sel_dividend;
  logic [DIVISOR_W-1:0]   sel_divisor;
  logic [QUOT_W-1:0]      core_quot;
  logic [REM_W-1:0]       core_rem;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && state_q == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_id_q;
        grant1 = ~last_id_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready   = grant0;
  assign req1_ready   = grant1;
  assign accept       = grant0 | grant1;
  assign accept_id    = grant1;
  assign sel_dividend = accept_id ? req1_dividend : req0_dividend;
  assign sel_divisor  = accept_id ? req1_divisor  : req0_divisor;

  div_core u_core (
    .dividend_i  (dividend_q),
    .divisor_i   (divisor_q),
    .quotient_o  (core_quot),
    .remainder_o (core_rem)
  );

  // Scheduler FSM: accept one operation, let the core settle, then hold the result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_id_q   <= 1'b1;
      cnt_q       <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_quot_q  <= '0;
      rsp_rem_q   <= '0;
      rsp_dbz_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            dividend_q <= sel_dividend;
            divisor_q  <= sel_divisor;
            id_q       <= accept_id;
            last_id_q  <= accept_id;
            busy_q     <= 1'b1;
            if (sel_divisor == '0) begin
              // Zero divisor skips the core entirely
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_id_q    <= accept_id;
              rsp_quot_q  <= DBZ_QUOTIENT;
              rsp_rem_q   <= sel_dividend[REM_W-1:0];
              rsp_dbz_q   <= 1'b1;
            end else begin
              state_q <= ST_COMPUTE;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        ST_COMPUTE: begin
          if (cnt_q == '0) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_quot_q  <= core_quot;
            rsp_rem_q   <= core_rem;
            rsp_dbz_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= done_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_quotient  = rsp_quot_q;
  assign rsp_remainder = rsp_rem_q;
  assign rsp_dbz       = rsp_dbz_q;
  assign busy          = busy_q;
  assign done_count    = done_q;

endmodule

// File: tb/tb_div_sched.sv
// tb/tb_div_sched.sv - scoreboard bench for the divide scheduler
module tb_div_sched;

  localparam int LAT = 2;

  typedef struct {
    int a;
    int b;
  } op_t;

  typedef struct {
    int id;
    int a;
    int b;
    int q;
    int r;
    int dbz;
    int lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rv [2];
  logic [7:0]  ra [2];
  logic [3:0]  rb [2];
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_dbz, busy;
  logic [7:0]  rsp_quotient;
  logic [3:0]  rsp_remainder;
  logic [15:0] done_count;
  logic [1:0]  rdy;

  int   n_tests = 0;
  int   n_fail = 0;
  op_t  ops_q [2][$];
  exp_t sb [$];
  exp_t resp_log [$];
  int   acc_ids [$];
  bit   fire [2];
  bit   in_flight = 0;
  int   last_g = 1;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   rsp_seen = 0;
  bit   hold_prev = 0;
  bit   rst_seen = 0;
  int   exp_done = 0;
  int   mode = 0;
  int   last_lat = 0;
  bit   e0, e1;
  exp_t e_new, e_top;
  logic [7:0] snap_q;
  logic [3:0] snap_r;
  logic       snap_id, snap_dbz;

  always #5 clk = ~clk;

  assign rdy = {req1_ready, req0_ready};

  div_sched #(.CORE_LAT(LAT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req0_valid    (rv[0]),
    .req0_ready    (req0_ready),
    .req0_dividend (ra[0]),
    .req0_divisor  (rb[0]),
    .req1_valid    (rv[1]),
    .req1_ready    (req1_ready),
    .req1_dividend (ra[1]),
    .req1_divisor  (rb[1]),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_dbz       (rsp_dbz),
    .busy          (busy),
    .done_count    (done_count)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send(input int n, input int a, input int b);
    op_t o;
    o.a = a;
    o.b = b;
    ops_q[n].push_back(o);
  endtask

  // Presents queued operations; operands are scrambled whenever valid is low
  task automatic driver(input int n);
    forever begin
      @(posedge clk);
      #1;
      if (fire[n]) begin
        void'(ops_q[n].pop_front());
        fire[n] = 0;
      end
      if (ops_q[n].size() > 0) begin
        rv[n] = 1'b1;
        ra[n] = 8'(ops_q[n][0].a);
        rb[n] = 4'(ops_q[n][0].b);
      end else begin
        rv[n] = 1'b0;
        ra[n] = 8'($urandom);
        rb[n] = 4'($urandom);
      end
    end
  endtask

  initial driver(0);
  initial driver(1);

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: rsp_ready = 1'b1;
        1: rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: arbitration model, acceptance into the scoreboard, response checks
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check("ready_in_reset", {req0_ready, req1_ready}, 0);
      sb.delete();
      in_flight = 0;
      exp_done  = 0;
      rst_seen  = 1;
      hold_prev = 0;
      rsp_seen  = 0;
      last_g    = 1;
      fire[0]   = 0;
      fire[1]   = 0;
    end else begin
      if (rst_seen) begin
        rst_seen = 0;
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_done_count", done_count, 0);
        check("rst_rsp_fields", {rsp_id, rsp_quotient, rsp_remainder, rsp_dbz}, 0);
      end
      check("done_count", done_count, exp_done);
      e0 = 0;
      e1 = 0;
      if (!in_flight) begin
        if (rv[0] && rv[1]) begin
          e0 = (last_g == 1);
          e1 = (last_g == 0);
        end else begin
          e0 = rv[0];
          e1 = rv[1];
        end
      end
      check("req0_ready", req0_ready, e0);
      check("req1_ready", req1_ready, e1);
      if (!in_flight) check("rsp_valid_without_op", rsp_valid, 0);
      if (hold_prev) begin
        check("hold_rsp_valid", rsp_valid, 1);
        check("hold_quotient", rsp_quotient, snap_q);
        check("hold_remainder", rsp_remainder, snap_r);
        check("hold_id", rsp_id, snap_id);
        check("hold_dbz", rsp_dbz, snap_dbz);
        hold_prev = 0;
      end
      if (rsp_valid && in_flight && sb.size() > 0) begin
        if (!rsp_seen) begin
          rsp_seen = 1;
          last_lat = cyc - acc_cyc;
          check("rsp_latency", last_lat, sb[0].lat);
        end
        if (rsp_ready) begin
          e_top = sb.pop_front();
          check("rsp_id", rsp_id, e_top.id);
          check("rsp_quotient", rsp_quotient, e_top.q);
          check("rsp_remainder", rsp_remainder, e_top.r);
          check("rsp_dbz", rsp_dbz, e_top.dbz);
          if (e_top.b != 0) begin
            check("identity", int'(rsp_quotient) * e_top.b + int'(rsp_remainder), e_top.a);
            check("rem_below_div", int'(rsp_remainder) < e_top.b, 1);
          end
          e_top.q   = int'(rsp_quotient);
          e_top.r   = int'(rsp_remainder);
          e_top.dbz = int'(rsp_dbz);
          e_top.id  = int'(rsp_id);
          resp_log.push_back(e_top);
          exp_done  = (exp_done + 1) % 65536;
          in_flight = 0;
        end else begin
          hold_prev = 1;
          snap_q    = rsp_quotient;
          snap_r    = rsp_remainder;
          snap_id   = rsp_id;
          snap_dbz  = rsp_dbz;
        end
      end
      for (int n = 0; n < 2; n++) begin
        if (rv[n] && rdy[n]) begin
          e_new.id = n;
          e_new.a  = int'(ra[n]);
          e_new.b  = int'(rb[n]);
          if (rb[n] == 0) begin
            e_new.q   = 255;
            e_new.r   = int'(ra[n]) % 16;
            e_new.dbz = 1;
            e_new.lat = 1;
          end else begin
            e_new.q   = int'(ra[n]) / int'(rb[n]);
            e_new.r   = int'(ra[n]) % int'(rb[n]);
            e_new.dbz = 0;
            e_new.lat = LAT + 1;
          end
          sb.push_back(e_new);
          acc_ids.push_back(n);
          in_flight = 1;
          acc_cyc   = cyc;
          rsp_seen  = 0;
          last_g    = n;
          fire[n]   = 1;
        end
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while ((ops_q[0].size() > 0 || ops_q[1].size() > 0 || in_flight || rv[0] || rv[1]) && k < 3000);
    if (k >= 3000) check("wait_idle_timeout", k, 0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int base;
    rv[0] = 1'b0;
    rv[1] = 1'b0;
    ra[0] = '0;
    ra[1] = '0;
    rb[0] = '0;
    rb[1] = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 200/7 on requester 0
    resp_log.delete();
    send(0, 200, 7);
    wait_idle();
    check("t_200_7_count", resp_log.size(), 1);
    if (resp_log.size() >= 1) begin
      check("t_200_7_q", resp_log[0].q, 28);
      check("t_200_7_r", resp_log[0].r, 4);
      check("t_200_7_id", resp_log[0].id, 0);
      check("t_200_7_dbz", resp_log[0].dbz, 0);
    end
    check("t_200_7_lat", last_lat, 3);
    check("t_200_7_done", done_count, 1);

    // divide by zero bypass
    resp_log.delete();
    send(0, 100, 0);
    wait_idle();
    check("t_dbz_count", resp_log.size(), 1);
    if (resp_log.size() >= 1) begin
      check("t_dbz_q", resp_log[0].q, 255);
      check("t_dbz_r", resp_log[0].r, 4);
      check("t_dbz_flag", resp_log[0].dbz, 1);
    end
    check("t_dbz_lat", last_lat, 1);

    // back-to-back on requester 1
    resp_log.delete();
    send(1, 255, 15);
    send(1, 9, 10);
    wait_idle();
    check("t_req1_count", resp_log.size(), 2);
    if (resp_log.size() >= 2) begin
      check("t_req1_q0", resp_log[0].q, 17);
      check("t_req1_r0", resp_log[0].r, 0);
      check("t_req1_q1", resp_log[1].q, 0);
      check("t_req1_r1", resp_log[1].r, 9);
      check("t_req1_id", resp_log[1].id, 1);
    end

    // both requesters contending
    acc_ids.delete();
    send(0, 50, 5);
    send(0, 51, 6);
    send(1, 52, 7);
    send(1, 53, 0);
    wait_idle();
    check("t_rr_count", acc_ids.size(), 4);
    if (acc_ids.size() >= 4) begin
      check("t_rr_id0", acc_ids[0], 0);
      check("t_rr_id1", acc_ids[1], 1);
      check("t_rr_id2", acc_ids[2], 0);
      check("t_rr_id3", acc_ids[3], 1);
    end

    // consumer stalls in RESP
    acc_ids.delete();
    mode = 2;
    base = exp_done;
    send(0, 77, 5);
    send(1, 33, 3);
    for (int k = 0; k < 200 && !(rsp_valid && in_flight); k++) begin
      @(negedge clk);
      #1;
    end
    check("t_stall_rsp_valid", rsp_valid, 1);
    repeat (5) begin
      @(negedge clk);
      #1;
    end
    check("t_stall_no_accept", acc_ids.size(), 1);
    check("t_stall_done", done_count, base);
    mode = 0;
    wait_idle();
    check("t_stall_accepts", acc_ids.size(), 2);

    // reset in the middle of COMPUTE
    resp_log.delete();
    send(0, 50, 3);
    for (int k = 0; k < 200 && !in_flight; k++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("t_rst_busy", busy, 0);
    check("t_rst_rsp_valid", rsp_valid, 0);
    check("t_rst_done", done_count, 0);
    send(0, 64, 8);
    wait_idle();
    check("t_rst_count", resp_log.size(), 1);
    if (resp_log.size() >= 1) begin
      check("t_rst_q", resp_log[0].q, 8);
      check("t_rst_r", resp_log[0].r, 0);
    end
    check("t_rst_done_after", done_count, 1);

    // randomized traffic with a stalling consumer
    resp_log.delete();
    mode = 1;
    for (int i = 0; i < 40; i++) begin
      send($urandom_range(0, 1), $urandom_range(0, 255),
           ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 15));
    end
    wait_idle();
    check("t_rand_count", resp_log.size(), 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1);
  end

endmodule
